// File: rtl/flash_arbiter_pkg.sv
// Shared definitions for the flash read-engine arbiter: FSM state
// encoding, port indices and read-size codes.
package flash_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam logic SIZE_16 = 1'b0;
  localparam logic SIZE_32 = 1'b1;

endpackage

// File: rtl/flash_arbiter_picker.sv
// Winner selection for the two flash requesters. Holds the last-grant
// flag (round-robin tie break) and the starvation counter used by the
// fixed-priority mode. The winner is combinational so the arbiter can
// grant in the same cycle it samples the requests; state only moves
// when the arbiter strobes advance.
module flash_arbiter_picker
  import flash_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic winner
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic       last_grant;
  logic [3:0] starve_count;
  logic       tie;

  assign tie = req0 & req1;

  // Pick the port to serve: a lone requester always wins, a tie is broken
  // by alternation or by fixed priority with a starvation escape.
  always_comb begin
    winner = PORT_CPU;
    if (tie) begin
      if (ROUND_ROBIN != 0) begin
        winner = ~last_grant;
      end else if (starve_count == LIMIT) begin
        winner = PORT_DMA;
      end else begin
        winner = PORT_CPU;
      end
    end else if (req1) begin
      winner = PORT_DMA;
    end
  end

  // Record each grant; count port-0 tie wins and clear on any port-1 grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant   <= PORT_DMA;
      starve_count <= 4'd0;
    end else if (advance) begin
      last_grant <= winner;
      if (winner == PORT_DMA) begin
        starve_count <= 4'd0;
      end else if (tie && (ROUND_ROBIN == 0)) begin
        starve_count <= starve_count + 4'd1;
      end
    end
  end

endmodule

// File: rtl/flash_arbiter.sv
// Arbiter sharing the QPI/CRM flash read engine between the CPU fetch
// port (0) and the DMA/asset loader port (1). Owns the engine's
// valid/address/size, returns engine data to the granted port with a
// one-cycle ready pulse. 16-bit reads return zero in the upper half.
// Optional feature: define FLASH_ARBITER_CACHE_EN to add a single-entry
// last-word cache for 32-bit reads, shared by both ports.
module flash_arbiter
  import flash_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_valid,
  input  logic [23:0] p0_address,
  input  logic        p0_size,
  output logic [31:0] p0_data,
  output logic        p0_ready,
  input  logic        p1_valid,
  input  logic [23:0] p1_address,
  input  logic        p1_size,
  output logic [31:0] p1_data,
  output logic        p1_ready,
  input  logic        cache_flush,
  output logic        rd_valid,
  output logic [23:0] rd_address,
  output logic        rd_size,
  input  logic [31:0] rd_data,
  input  logic        rd_ready
);

  state_t      state;
  logic        grant;
  logic        winner;
  logic        advance;
  logic [23:0] win_address;
  logic        win_size;
  logic [31:0] engine_word;
  logic        cache_hit;
  logic [31:0] cache_word;

  assign advance     = (state == IDLE) && (p0_valid || p1_valid);
  assign win_address = (winner == PORT_DMA) ? p1_address : p0_address;
  assign win_size    = (winner == PORT_DMA) ? p1_size : p0_size;
  assign engine_word = (rd_size == SIZE_32) ? rd_data : {16'h0000, rd_data[15:0]};

  flash_arbiter_picker #(
    .ROUND_ROBIN (ROUND_ROBIN),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_picker (
    .clk    (clk),
    .reset  (reset),
    .req0   (p0_valid),
    .req1   (p1_valid),
    .advance(advance),
    .winner (winner)
  );

`ifdef FLASH_ARBITER_CACHE_EN
  logic        cache_valid;
  logic [23:0] cache_tag;

  // Remember the last completed 32-bit engine read; a flush beats a fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_tag   <= 24'h000000;
      cache_word  <= 32'h00000000;
    end else begin
      if ((state == BUSY) && rd_ready && (rd_size == SIZE_32)) begin
        cache_valid <= 1'b1;
        cache_tag   <= rd_address;
        cache_word  <= rd_data;
      end
      if (cache_flush) begin
        cache_valid <= 1'b0;
      end
    end
  end

  assign cache_hit = cache_valid && (win_size == SIZE_32) && (win_address == cache_tag);
`else
  logic unused_cache_flush;

  assign unused_cache_flush = cache_flush;
  assign cache_hit          = 1'b0;
  assign cache_word         = 32'h00000000;
`endif

  // Grant / engine handshake / completion sequencing with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= PORT_CPU;
      rd_valid   <= 1'b0;
      rd_address <= 24'h000000;
      rd_size    <= SIZE_16;
      p0_ready   <= 1'b0;
      p1_ready   <= 1'b0;
      p0_data    <= 32'h00000000;
      p1_data    <= 32'h00000000;
    end else begin
      case (state)
        IDLE: begin
          if (p0_valid || p1_valid) begin
            grant <= winner;
            if (cache_hit) begin
              if (winner == PORT_DMA) begin
                p1_data  <= cache_word;
                p1_ready <= 1'b1;
              end else begin
                p0_data  <= cache_word;
                p0_ready <= 1'b1;
              end
              state <= DONE;
            end else begin
              rd_valid   <= 1'b1;
              rd_address <= win_address;
              rd_size    <= win_size;
              state      <= BUSY;
            end
          end
        end
        BUSY: begin
          if (rd_ready) begin
            if (grant == PORT_DMA) begin
              p1_data  <= engine_word;
              p1_ready <= 1'b1;
            end else begin
              p0_data  <= engine_word;
              p0_ready <= 1'b1;
            end
            rd_valid <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          p0_ready <= 1'b0;
          p1_ready <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed self-checking bench for flash_arbiter. Instance 0 runs in
// round-robin mode, instance 1 in fixed-priority mode with a starvation
// limit of 2. The bench plays the flash engine for each instance.
// Cache checks are compiled in only with FLASH_ARBITER_CACHE_EN.
module tb_flash_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cache_flush = 1'b1;

  logic        p0_valid   [2];
  logic [23:0] p0_address [2];
  logic        p0_size    [2];
  logic [31:0] p0_data    [2];
  logic        p0_ready   [2];
  logic        p1_valid   [2];
  logic [23:0] p1_address [2];
  logic        p1_size    [2];
  logic [31:0] p1_data    [2];
  logic        p1_ready   [2];
  logic        rd_valid   [2];
  logic [23:0] rd_address [2];
  logic        rd_size    [2];
  logic [31:0] rd_data    [2];
  logic        rd_ready   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flash_arbiter #(.ROUND_ROBIN(1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid[0]), .p0_address(p0_address[0]), .p0_size(p0_size[0]),
    .p0_data(p0_data[0]), .p0_ready(p0_ready[0]),
    .p1_valid(p1_valid[0]), .p1_address(p1_address[0]), .p1_size(p1_size[0]),
    .p1_data(p1_data[0]), .p1_ready(p1_ready[0]),
    .cache_flush(cache_flush),
    .rd_valid(rd_valid[0]), .rd_address(rd_address[0]), .rd_size(rd_size[0]),
    .rd_data(rd_data[0]), .rd_ready(rd_ready[0])
  );

  flash_arbiter #(.ROUND_ROBIN(0), .STARVE_LIMIT(2)) dut_fp (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid[1]), .p0_address(p0_address[1]), .p0_size(p0_size[1]),
    .p0_data(p0_data[1]), .p0_ready(p0_ready[1]),
    .p1_valid(p1_valid[1]), .p1_address(p1_address[1]), .p1_size(p1_size[1]),
    .p1_data(p1_data[1]), .p1_ready(p1_ready[1]),
    .cache_flush(cache_flush),
    .rd_valid(rd_valid[1]), .rd_address(rd_address[1]), .rd_size(rd_size[1]),
    .rd_data(rd_data[1]), .rd_ready(rd_ready[1])
  );

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge, where outputs are sampled and inputs driven.
  task automatic tick();
    @(negedge clk);
  endtask

  // Drive one requester of one instance.
  task automatic applyStimulus(input int d, input int port, input logic valid,
                               input logic [23:0] addr, input logic size);
    if (port == 0) begin
      p0_valid[d] = valid; p0_address[d] = addr; p0_size[d] = size;
    end else begin
      p1_valid[d] = valid; p1_address[d] = addr; p1_size[d] = size;
    end
  endtask

  // Wait a bounded number of cycles for the engine request to appear.
  task automatic waitValid(input int d, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!rd_valid[d] && cycles < 50);
    checkOutput("rd_valid seen", 32'(rd_valid[d]), 32'd1);
  endtask

  // Play the engine: hold for lat cycles, then pulse ready with data.
  task automatic engineServe(input int d, input int lat, input logic [31:0] word,
                             input logic [23:0] addr);
    repeat (lat - 1) tick();
    checkOutput("rd_valid held", 32'(rd_valid[d]), 32'd1);
    checkOutput("rd_address held", 32'(rd_address[d]), 32'(addr));
    rd_data[d]  = word;
    rd_ready[d] = 1'b1;
    tick();
    rd_ready[d] = 1'b0;
    rd_data[d]  = 32'h5A5A5A5A;
  endtask

  // Completion cycle: only the granted port pulses ready with the right data.
  task automatic checkDone(input int d, input int port, input logic [31:0] word);
    if (port == 0) begin
      checkOutput("p0_ready pulse", 32'(p0_ready[d]), 32'd1);
      checkOutput("p0_data", p0_data[d], word);
      checkOutput("p1_ready quiet", 32'(p1_ready[d]), 32'd0);
    end else begin
      checkOutput("p1_ready pulse", 32'(p1_ready[d]), 32'd1);
      checkOutput("p1_data", p1_data[d], word);
      checkOutput("p0_ready quiet", 32'(p0_ready[d]), 32'd0);
    end
    checkOutput("rd_valid dropped", 32'(rd_valid[d]), 32'd0);
  endtask

  // Both ports request continuously; bit i of pattern is the expected grant i.
  task automatic tieSequence(input int d, input int n, input logic [7:0] pattern,
                             input string tag);
    int cyc;
    int granted;
    applyStimulus(d, 0, 1'b1, 24'h000400, 1'b1);
    applyStimulus(d, 1, 1'b1, 24'h000800, 1'b1);
    for (int i = 0; i < n; i++) begin
      waitValid(d, cyc);
      checkOutput($sformatf("%s latency %0d", tag, i), 32'(cyc), 32'd1);
      granted = (rd_address[d] == 24'h000800) ? 1 : 0;
      checkOutput($sformatf("%s grant %0d", tag, i), 32'(granted), 32'(pattern[i]));
      engineServe(d, 3, 32'h00000100 + 32'(i), rd_address[d]);
      checkDone(d, granted, 32'h00000100 + 32'(i));
      if (granted == 1) p1_valid[d] = 1'b0;
      else p0_valid[d] = 1'b0;
      tick();
      checkOutput($sformatf("%s gap %0d", tag, i), 32'(rd_valid[d]), 32'd0);
      if (i < n - 1) begin
        if (granted == 1) p1_valid[d] = 1'b1;
        else p0_valid[d] = 1'b1;
      end
    end
    p0_valid[d] = 1'b0;
    p1_valid[d] = 1'b0;
  endtask

  initial begin
    int cyc;
    for (int d = 0; d < 2; d++) begin
      applyStimulus(d, 0, 1'b0, 24'h000000, 1'b0);
      applyStimulus(d, 1, 1'b0, 24'h000000, 1'b0);
      rd_data[d]  = 32'h00000000;
      rd_ready[d] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) tick();

    // Reset values
    checkOutput("reset rd_valid", 32'(rd_valid[0]), 32'd0);
    checkOutput("reset rd_address", 32'(rd_address[0]), 32'd0);
    checkOutput("reset rd_size", 32'(rd_size[0]), 32'd0);
    checkOutput("reset p0_ready", 32'(p0_ready[0]), 32'd0);
    checkOutput("reset p1_ready", 32'(p1_ready[0]), 32'd0);
    checkOutput("reset p0_data", p0_data[0], 32'd0);
    checkOutput("reset p1_data", p1_data[0], 32'd0);
    checkOutput("reset fp rd_valid", 32'(rd_valid[1]), 32'd0);
    reset = 1'b0;

    // Port 0 alone, 32-bit read, 20-cycle engine
    applyStimulus(0, 0, 1'b1, 24'h010000, 1'b1);
    waitValid(0, cyc);
    checkOutput("p0 grant latency", 32'(cyc), 32'd1);
    checkOutput("p0 rd_address", 32'(rd_address[0]), 32'h00010000);
    checkOutput("p0 rd_size", 32'(rd_size[0]), 32'd1);
    p0_address[0] = 24'h123456;
    engineServe(0, 20, 32'hDEADBEEF, 24'h010000);
    checkDone(0, 0, 32'hDEADBEEF);
    p0_valid[0] = 1'b0;
    tick();
    checkOutput("p0_ready one cycle", 32'(p0_ready[0]), 32'd0);
    checkOutput("p0_data kept", p0_data[0], 32'hDEADBEEF);

    // Engine ready while idle must not produce a completion
    rd_data[0]  = 32'h11111111;
    rd_ready[0] = 1'b1;
    tick();
    rd_ready[0] = 1'b0;
    checkOutput("idle ready p0", 32'(p0_ready[0]), 32'd0);
    checkOutput("idle ready p1", 32'(p1_ready[0]), 32'd0);
    checkOutput("idle ready rd_valid", 32'(rd_valid[0]), 32'd0);

    // Port 1, 16-bit read: upper half forced to zero
    applyStimulus(0, 1, 1'b1, 24'h000102, 1'b0);
    waitValid(0, cyc);
    checkOutput("p1 rd_address", 32'(rd_address[0]), 32'h00000102);
    checkOutput("p1 rd_size", 32'(rd_size[0]), 32'd0);
    engineServe(0, 4, 32'hBEEF3412, 24'h000102);
    checkDone(0, 1, 32'h00003412);
    checkOutput("p0_data untouched", p0_data[0], 32'hDEADBEEF);
    p1_valid[0] = 1'b0;
    tick();

    // Round robin: last grant was port 1, so ties go 0,1,0,1
    tieSequence(0, 4, 8'b0000_1010, "rr");
    tick();

    // Reset in the middle of an engine read
    applyStimulus(0, 0, 1'b1, 24'h000600, 1'b1);
    waitValid(0, cyc);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("midbusy rd_valid", 32'(rd_valid[0]), 32'd0);
    checkOutput("midbusy rd_address", 32'(rd_address[0]), 32'd0);
    checkOutput("midbusy p0_ready", 32'(p0_ready[0]), 32'd0);
    checkOutput("midbusy p0_data", p0_data[0], 32'd0);
    reset = 1'b0;
    waitValid(0, cyc);
    checkOutput("after reset latency", 32'(cyc), 32'd1);
    checkOutput("after reset address", 32'(rd_address[0]), 32'h00000600);
    engineServe(0, 5, 32'hCAFEF00D, 24'h000600);
    checkDone(0, 0, 32'hCAFEF00D);
    p0_valid[0] = 1'b0;
    tick();

    // Fixed priority with starvation limit 2: 0,0,1,0,0,1
    tieSequence(1, 6, 8'b0010_0100, "fp");
    tick();

`ifdef FLASH_ARBITER_CACHE_EN
    // Fill the cache, hit it, flush it, miss again
    cache_flush = 1'b0;
    tick();
    applyStimulus(0, 0, 1'b1, 24'h000200, 1'b1);
    waitValid(0, cyc);
    engineServe(0, 2, 32'h12345678, 24'h000200);
    checkDone(0, 0, 32'h12345678);
    p0_valid[0] = 1'b0;
    tick();
    rd_data[0]  = 32'h00000000;
    p0_valid[0] = 1'b1;
    tick();
    checkOutput("cache hit ready", 32'(p0_ready[0]), 32'd1);
    checkOutput("cache hit data", p0_data[0], 32'h12345678);
    checkOutput("cache hit rd_valid", 32'(rd_valid[0]), 32'd0);
    p0_valid[0] = 1'b0;
    tick();
    checkOutput("cache hit no engine", 32'(rd_valid[0]), 32'd0);
    cache_flush = 1'b1;
    tick();
    cache_flush = 1'b0;
    p0_valid[0] = 1'b1;
    waitValid(0, cyc);
    checkOutput("flushed miss latency", 32'(cyc), 32'd1);
    checkOutput("flushed miss address", 32'(rd_address[0]), 32'h00000200);
    engineServe(0, 2, 32'h87654321, 24'h000200);
    checkDone(0, 0, 32'h87654321);
    p0_valid[0] = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
